// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer state encoding, default widths.
// Imported by the command sequencer, its settle counter, EX and the benches.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SW_W_DEF   = 16;
  localparam int OP_W_DEF   = 6;
  localparam int RES_W_DEF  = 9;
  localparam int CNT_W      = 4;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_SETTLE = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter with zero flag; times the EX settle window.
// Ports: clock, reset_n (sync, active low), load/load_val, dec -> count, zero.
module alu_settle_counter
  import alu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Turns an A,B,OP byte stream into EX load strobes and returns the result
// on a valid/ready handshake. Ports: clock, reset_n (sync, active low),
// rx_data/rx_valid in; sw, btn_a/b/op out to EX; alu_res/alu_carry in;
// res_data/res_carry/res_valid out with res_ready in; err pulse out.
// Build option OPCODE_CHECK_EN: reject opcodes outside the legal set.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SW_W       = SW_W_DEF,
  parameter int OP_W       = OP_W_DEF,
  parameter int RES_W      = RES_W_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [SW_W-1:0]   sw,
  output logic              btn_a,
  output logic              btn_b,
  output logic              btn_op,
  input  logic [RES_W-1:0]  alu_res,
  input  logic              alu_carry,
  output logic [RES_W-1:0]  res_data,
  output logic              res_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              err
);

  state_t state, state_nxt;

  logic [SW_W-1:0]  sw_nxt;
  logic             btn_a_nxt;
  logic             btn_b_nxt;
  logic             btn_op_nxt;
  logic [RES_W-1:0] res_data_nxt;
  logic             res_carry_nxt;
  logic             res_valid_nxt;
  logic             err_nxt;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  logic [SW_W-1:0]  byte_ext;
  logic [OP_W-1:0]  op_byte;
  logic [SW_W-1:0]  op_ext;

  assign byte_ext = {{(SW_W-DATA_W){1'b0}}, rx_data};
  assign op_byte  = rx_data[OP_W-1:0];
  assign op_ext   = {{(SW_W-OP_W){1'b0}}, op_byte};

  alu_settle_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cnt_load),
    .load_val(CNT_W'(SETTLE_CYC)),
    .dec     (cnt_dec),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_nxt     = state;
    sw_nxt        = sw;
    btn_a_nxt     = 1'b0;
    btn_b_nxt     = 1'b0;
    btn_op_nxt    = 1'b0;
    res_data_nxt  = res_data;
    res_carry_nxt = res_carry;
    res_valid_nxt = res_valid;
    err_nxt       = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    unique case (state)
      S_GET_A: begin
        if (rx_valid) begin
          sw_nxt    = byte_ext;
          btn_a_nxt = 1'b1;
          state_nxt = S_GET_B;
        end
      end
      S_GET_B: begin
        if (rx_valid) begin
          sw_nxt    = byte_ext;
          btn_b_nxt = 1'b1;
          state_nxt = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (rx_valid) begin
`ifdef OPCODE_CHECK_EN
          if (!op_legal(6'(op_byte))) begin
            // sw is left alone so EX keeps its latched operands
            err_nxt   = 1'b1;
            state_nxt = S_GET_A;
          end else begin
            sw_nxt     = op_ext;
            btn_op_nxt = 1'b1;
            cnt_load   = 1'b1;
            state_nxt  = S_SETTLE;
          end
`else
          sw_nxt     = op_ext;
          btn_op_nxt = 1'b1;
          cnt_load   = 1'b1;
          state_nxt  = S_SETTLE;
`endif
        end
      end
      S_SETTLE: begin
        err_nxt = rx_valid;
        if (cnt_zero) begin
          res_data_nxt  = alu_res;
          res_carry_nxt = alu_carry;
          res_valid_nxt = 1'b1;
          state_nxt     = S_RESULT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_RESULT: begin
        err_nxt = rx_valid;
        if (res_valid && res_ready) begin
          res_valid_nxt = 1'b0;
          state_nxt     = S_GET_A;
        end
      end
      default: begin
        state_nxt = S_GET_A;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_GET_A;
      sw        <= '0;
      btn_a     <= 1'b0;
      btn_b     <= 1'b0;
      btn_op    <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      sw        <= sw_nxt;
      btn_a     <= btn_a_nxt;
      btn_b     <= btn_b_nxt;
      btn_op    <= btn_op_nxt;
      res_data  <= res_data_nxt;
      res_carry <= res_carry_nxt;
      res_valid <= res_valid_nxt;
      err       <= err_nxt;
    end
  end

endmodule
